// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
// The master drives the operands and start; the slave returns the results and status.
interface seq_divider_if #(
   parameter int unsigned W = 4
);
   logic         start;
   logic [W-1:0] Dividend;
   logic [W-1:0] Divisor;
   logic [W-1:0] Q;
   logic [W-1:0] Rem;
   logic         busy;
   logic         done;
   logic         DivZero;

   modport master (
      output start, Dividend, Divisor,
      input  Q, Rem, busy, done, DivZero
   );

   modport slave (
      input  start, Dividend, Divisor,
      output Q, Rem, busy, done, DivZero
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned non-restoring divider: one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_TRAP_EN: a zero divisor finishes on the accepting edge and raises DivZero.
module seq_divider #(
   parameter int unsigned W = 4
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [W:0]    a_q, a_d;
   logic [W-1:0]  m_q, m_d;
   logic [W-1:0]  qr_q, qr_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [CW-1:0] count_q, count_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          trap;
   logic [W:0]    a_sh, a_step, a_fix;
`ifdef DIV_ZERO_TRAP_EN
   logic          div_zero_q, div_zero_d;

   assign trap = (bus.Divisor == '0);
`else
   assign trap = 1'b0;
`endif

   // Sign of the old partial remainder picks add or subtract, as in the add/sub datapath.
   assign a_sh   = {a_q[W-1:0], qr_q[W-1]};
   assign a_step = a_q[W] ? a_sh + {1'b0, m_q} : a_sh - {1'b0, m_q};
   assign a_fix  = a_q[W] ? a_q + {1'b0, m_q} : a_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      qr_d    = qr_q;
      count_d = count_q;
      q_d     = q_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_d = div_zero_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               if (trap) begin
                  q_d     = '1;
                  rem_d   = bus.Dividend;
                  done_d  = 1'b1;
                  state_d = StDone;
`ifdef DIV_ZERO_TRAP_EN
                  div_zero_d = 1'b1;
`endif
               end else begin
                  a_d     = '0;
                  qr_d    = bus.Dividend;
                  m_d     = bus.Divisor;
                  count_d = CW'(W);
                  busy_d  = 1'b1;
                  state_d = StRun;
`ifdef DIV_ZERO_TRAP_EN
                  div_zero_d = 1'b0;
`endif
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d     = a_step;
            qr_d    = {qr_q[W-2:0], ~a_step[W]};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            a_d     = a_fix;
            q_d     = qr_q;
            rem_d   = a_fix[W-1:0];
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         m_q     <= '0;
         qr_q    <= '0;
         count_q <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         qr_q    <= qr_d;
         count_q <= count_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_q <= div_zero_d;
`endif
      end
   end

   assign bus.Q    = q_q;
   assign bus.Rem  = rem_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
`ifdef DIV_ZERO_TRAP_EN
   assign bus.DivZero = div_zero_q;
`else
   assign bus.DivZero = 1'b0;
`endif
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned non-restoring divider, the inverse of the team's add/sub datapath.
- Computes Q = Dividend / Divisor and Rem = Dividend mod Divisor, one quotient bit per clock.
- Each cycle is a single (W+1)-bit add or subtract. Which one is selected by the sign of the partial remainder, the same mode-select idea the add/sub block uses with Cin.
- Sits beside the ALU as a multi-cycle functional unit with a start/done handshake.

Parameters:
- W, 4, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- Dividend  input  W  unsigned dividend, captured on accepting edge
- Divisor  input  W  unsigned divisor, captured on accepting edge
- Q  output  W  quotient, registered
- Rem  output  W  remainder, registered
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when Q/Rem become valid
- DivZero  output  1  divide-by-zero flag, valid with done

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - Q=0, Rem=0, busy=0, done=0, DivZero=0.
  - Internal A (W+1 bits), M, QR (W bits) and count all cleared.
  - Applies immediately, including mid-operation. The operation in flight is discarded and no done is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with start=1 at an edge (accept):
  - A=0, QR=Dividend, M=Divisor, count=W.
  - state=RUN, busy=1.
  - In DONE, this allows back-to-back operations.
- IDLE with start=0: stay IDLE.
- DONE with start=0: go to IDLE. done=1 for exactly that one DONE cycle.
- RUN, each edge:
  - {A,QR} shifted left one bit.
  - If the old A sign bit is 0: A = shifted A - {0,M}; else A = shifted A + {0,M}.
  - QR[0] = inverse of the new A sign bit.
  - count decrements. When count reaches 1 on this edge, next state is FIX.
- FIX, one edge:
  - If A is negative, A = A + {0,M}.
  - Q=QR, Rem=A[W-1:0], DivZero per the optional feature.
  - state=DONE, busy=0, done=1.
- Latency: accepting edge E0. RUN on edges E1..EW, FIX on edge E(W+1). done is high from E(W+1) to E(W+2). Throughput is one result per W+2 cycles.
- start while busy (RUN/FIX) is ignored. Operands in flight are unaffected by input changes.
- Q/Rem hold their last values until the next FIX. They are not cleared by a new start.
- Arithmetic is unsigned. A is W+1 bits two's-complement internally and never overflows for unsigned operands.
- Divisor=0 (feature off): the algorithm yields Q = all ones, Rem = Dividend, with full W+2 latency.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- Defined:
  - An accepted start with Divisor=0 skips RUN and FIX.
  - On E0: Q = all ones, Rem = Dividend, DivZero=1, state=DONE. done is high from E0 to E1.
  - busy stays 0 throughout.
  - DivZero clears on the next accept with a nonzero Divisor, or on reset.
- Not defined:
  - DivZero is tied 0.
  - Divide-by-zero takes the normal path with full latency and the results given in Behaviour.

Test Plan:
- W=4, Dividend=13, Divisor=3, start pulse -> done exactly 5 edges after accept; Q=4, Rem=1, DivZero=0.
- 15/1 -> Q=15, Rem=0. 5/7 -> Q=0, Rem=5. 0/5 -> Q=0, Rem=0.
- Back-to-back: start held high from IDLE with 9/2 then 14/4 -> done pulses 6 cycles apart; Q/Rem = 4/1, then 3/2.
- start pulsed in RUN with 1/1 while computing 12/5 -> ignored; result Q=2, Rem=2.
- rst_n low during the 2nd RUN cycle of 11/3 -> outputs 0 immediately, no done. A fresh 11/3 afterwards -> Q=3, Rem=2.
- 7/0 -> with DIV_ZERO_TRAP_EN: done on E0, Q=15, Rem=7, DivZero=1. Without: done after 5 edges, Q=15, Rem=7, DivZero=0.
